// File: rtl/tick_sched.sv
// Programmable tick scheduler: a loadable prescaler emits single-cycle tick
// enables, either free-running or as a one-shot burst of cfg_ticks pulses.
module tick_sched #(
  parameter int          CNT_W       = 25,
  parameter int unsigned DEFAULT_DIV = 33554431,
  parameter int          TCNT_W      = 8
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              cfg_load,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [TCNT_W-1:0] cfg_ticks,
  input  logic              start,
  input  logic              pause,
  input  logic              stop,
  output logic              tick,
  output logic [TCNT_W-1:0] tick_cnt,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]        state;
  logic [CNT_W-1:0]  pre_cnt;
  logic [CNT_W-1:0]  div_reg;
  logic [TCNT_W-1:0] ticks_reg;
  logic [TCNT_W-1:0] tick_cnt_inc;

  assign tick_cnt_inc = tick_cnt + 1'b1;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state     <= ST_IDLE;
      pre_cnt   <= '0;
      div_reg   <= CNT_W'(DEFAULT_DIV);
      ticks_reg <= '0;
      tick      <= 1'b0;
      tick_cnt  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          tick <= 1'b0;
          done <= 1'b0;
          if (cfg_load) begin
            div_reg   <= cfg_div;
            ticks_reg <= cfg_ticks;
            cfg_err   <= 1'b0;
          end
          if (start && !stop) begin
            state    <= ST_RUN;
            pre_cnt  <= '0;
            tick_cnt <= '0;
            busy     <= 1'b1;
          end
        end

        // stop outranks pause, which outranks prescaler progress
        ST_RUN: begin
          if (cfg_load) cfg_err <= 1'b1;
          if (stop) begin
            state   <= ST_IDLE;
            tick    <= 1'b0;
            pre_cnt <= '0;
            busy    <= 1'b0;
          end else if (pause) begin
            state <= ST_PAUSE;
            tick  <= 1'b0;
          end else if (pre_cnt == div_reg) begin
            pre_cnt  <= '0;
            tick     <= 1'b1;
            tick_cnt <= tick_cnt_inc;
            if (ticks_reg != '0 && tick_cnt_inc == ticks_reg) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            pre_cnt <= pre_cnt + 1'b1;
            tick    <= 1'b0;
          end
        end

        ST_PAUSE: begin
          tick <= 1'b0;
          if (cfg_load) cfg_err <= 1'b1;
          if (stop) begin
            state   <= ST_IDLE;
            pre_cnt <= '0;
            busy    <= 1'b0;
          end else if (!pause) begin
            state <= ST_RUN;
          end
        end

        ST_DONE: begin
          if (cfg_load) cfg_err <= 1'b1;
          state <= ST_IDLE;
          tick  <= 1'b0;
          done  <= 1'b0;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
